ram_frame_reader: RTL and testbench
===================================

# ram_frame_reader

Streaming read-out stage that sits directly downstream of the simple dual-port frame RAM. On a `start` pulse it sweeps the RAM read address from 0 to DEPTH-1 and hides the RAM's one-cycle read latency. It delivers each word exactly once on a ready/valid stream, with row and frame markers, to the LED/display driver. A 2-entry output buffer allows full throughput (one word per cycle) under arbitrary `out_ready` backpressure.

## Interface
- `SIZE`, 8: word width in bits; must equal the RAM word size.
- `DEPTH`, 8: number of RAM entries per frame; DEPTH ≥ 2.
- `COLS`, 4: words per display row; DEPTH must be an integer multiple of COLS.

- `clk`  in  1  single clock; also drives the RAM read clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin one frame; sampled only in IDLE.
- `raddr`  out  $clog2(DEPTH)  RAM read address, registered.
- `ram_data`  in  SIZE  RAM read data; equals mem[raddr of the previous cycle].
- `out_data`  out  SIZE  streamed word.
- `out_valid`  out  1  `out_data` and the markers are valid.
- `out_ready`  in  1  consumer accepts; a transfer occurs when valid & ready.
- `out_eol`  out  1  current word is the last of its row (column index = COLS-1).
- `out_last`  out  1  current word is address DEPTH-1.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse in the cycle after the last word transfers.

## Operation
- States:
  - IDLE: `start`=1 → RUN, with rd_ptr=0, buffer empty, inflight=0.
  - RUN: after all DEPTH words are issued and the last word transfers → IDLE (or wrap, see Configuration).
- Issue rule (RUN only): issue a read in cycle k when words remain to issue and (buf_count + inflight − pop_k) < 2.
  - pop_k = out_valid & out_ready in cycle k.
  - Issue sets inflight for cycle k+1 and advances rd_ptr. `raddr` tracks rd_ptr and holds when not issuing.
- Capture: when inflight=1, `ram_data` is written into the buffer tail at the end of that cycle. The buffer never overflows.
- Output:
  - head of buffer drives `out_data`; `out_valid` = buf_count≠0.
  - data and markers stay stable while valid & !ready.
- Markers:
  - out_col counter (0..COLS-1) and out_idx counter (0..DEPTH-1) advance on each transfer.
  - `out_eol` = (out_col==COLS-1); `out_last` = (out_idx==DEPTH-1); both gated by `out_valid`.
- `start` while RUN: ignored. A `start` in the same cycle the FSM returns to IDLE is ignored; a new frame requires `start` in IDLE.
- RAM contents are read as-is; the writer must not update the frame during a sweep (no coherence check).

## Timing
- Reset values: `raddr`=0, `out_data`=0, `out_valid`=0, `out_eol`=0, `out_last`=0, `busy`=0, `frame_done`=0. Buffer, inflight, rd_ptr and counters are cleared.
- `rst` mid-frame: next cycle all outputs are at reset values; in-flight read discarded; FSM in IDLE.
- Latency:
  - `start`=1 in cycle 0 → `busy`=1 and `raddr`=0 issued in cycle 1.
  - `ram_data`=mem[0] in cycle 2.
  - `out_valid`=1 with `out_data`=mem[0] in cycle 3.
- Throughput: with `out_ready` held at 1, one word per cycle. Frame of DEPTH words occupies cycles 3..DEPTH+2; `frame_done` is in cycle DEPTH+3, with `busy`=0 in that same cycle.
- Backpressure: `out_ready`=0 for N cycles stalls issue after at most 2 words are buffered/in flight. No word is lost or duplicated.
- `frame_done` and `out_valid` are never high in the same cycle when the repeat feature is disabled.

## Configuration
- `RAM_FRAME_READER_REPEAT_EN` defined:
  - after issuing DEPTH-1, rd_ptr wraps to 0 and issue continues without a bubble; out_idx and out_col wrap likewise.
  - `frame_done` pulses in the cycle after each `out_last` transfer; the FSM stays in RUN and `busy` stays 1 until `rst`.
- Not defined: one frame per `start`, then IDLE as described above.

## Test plan
- Reset/idle: hold `rst` 3 cycles with garbage inputs → all outputs 0; `start`=0 for 10 cycles → `raddr` stays 0, `busy`=0.
- Full-rate frame: RAM preloaded mem[i]=8'hA0+i, DEPTH=8, COLS=4, `out_ready`=1, `start` in cycle 0 → words A0..A7 in cycles 3..10; `out_eol` on A3 and A7; `out_last` on A7; `frame_done` in cycle 11.
- Backpressure: `out_ready` toggles with pattern 1,0,0,1,0,1… → exact sequence A0..A7 with no duplicates or drops; `out_data` stable across every stall; `raddr` never runs more than 2 words ahead of accepted output.
- Start during RUN: second `start` pulse in cycle 5 → ignored; exactly 8 words and one `frame_done`.
- Reset mid-frame: `rst` in cycle 6 → cycle 7 outputs at reset values; a later `start` streams A0..A7 from address 0.
- Repeat (`RAM_FRAME_READER_REPEAT_EN`): `out_ready`=1, one `start` → continuous A0..A7,A0..; `frame_done` every 8 cycles; no gap at the wrap.

Source files
------------

// File: rtl/ram_frame_reader.sv
// Frame RAM read-out stage: sweeps addresses 0..DEPTH-1 and streams words with row/frame markers.
// Optional continuous wrap-around sweeping is enabled with `define RAM_FRAME_READER_REPEAT_EN.
module ram_frame_reader #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 8,
  parameter int COLS  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  output logic [$clog2(DEPTH)-1:0] o_raddr,
  input  logic [SIZE-1:0]          i_ram_data,
  output logic [SIZE-1:0]          o_out_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_out_eol,
  output logic                     o_out_last,
  output logic                     o_busy,
  output logic                     o_frame_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic [AW-1:0] r_rd_ptr;
  logic          r_iss_done;
  logic          r_inflight;
  logic [SIZE-1:0] r_buf [2];
  logic          r_wp, r_rp;
  logic [1:0]    r_cnt;
  logic [CW-1:0] r_col;
  logic [AW-1:0] r_idx;
  logic          r_frame_done;

  logic          w_pop, w_issue, w_last_xfer, w_end;
  logic [2:0]    w_occ;

  assign w_pop       = o_out_valid & i_out_ready;
  assign w_last_xfer = w_pop & (r_idx == LAST_ADDR);
  // Occupancy after this cycle's pop; a read may only be issued if it has a guaranteed slot.
  assign w_occ       = {1'b0, r_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue     = (r_state == ST_RUN) & ~r_iss_done & (w_occ < 3'd2);
`ifdef RAM_FRAME_READER_REPEAT_EN
  assign w_end       = 1'b0;
`else
  assign w_end       = w_last_xfer;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_rd_ptr     <= '0;
      r_iss_done   <= 1'b0;
      r_inflight   <= 1'b0;
      r_buf[0]     <= '0;
      r_buf[1]     <= '0;
      r_wp         <= 1'b0;
      r_rp         <= 1'b0;
      r_cnt        <= '0;
      r_col        <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_xfer;
      if (r_state == ST_IDLE) begin
        if (i_start) r_state <= ST_RUN;
      end else if (w_end) begin
        r_state    <= ST_IDLE;
        r_iss_done <= 1'b0;
      end
      if (w_issue) begin
        r_rd_ptr <= (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + AW'(1);
`ifndef RAM_FRAME_READER_REPEAT_EN
        r_iss_done <= (r_rd_ptr == LAST_ADDR);
`endif
      end
      r_inflight <= w_issue;
      if (r_inflight) begin
        r_buf[r_wp] <= i_ram_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp  <= ~r_rp;
        r_col <= (r_col == LAST_COL)  ? '0 : r_col + CW'(1);
        r_idx <= (r_idx == LAST_ADDR) ? '0 : r_idx + AW'(1);
      end
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  assign o_raddr      = r_rd_ptr;
  assign o_out_data   = r_buf[r_rp];
  assign o_out_valid  = (r_cnt != 2'd0);
  assign o_out_eol    = o_out_valid & (r_col == LAST_COL);
  assign o_out_last   = o_out_valid & (r_idx == LAST_ADDR);
  assign o_busy       = (r_state == ST_RUN);
  assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_ram_frame_reader.sv
// Randomized self-checking bench for ram_frame_reader with a behavioural RAM and stream scoreboard.
module tb_ram_frame_reader;
  localparam int SIZE = 8, DEPTH = 8, COLS = 4;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [2:0] raddr;
  logic [SIZE-1:0] ram_data, out_data;
  logic out_valid, out_eol, out_last, busy, frame_done;
  logic [SIZE-1:0] mem [DEPTH];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ram_data <= mem[raddr];

  ram_frame_reader #(.SIZE(SIZE), .DEPTH(DEPTH), .COLS(COLS)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_raddr(raddr),
    .i_ram_data(ram_data), .o_out_data(out_data), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_eol(out_eol), .o_out_last(out_last),
    .o_busy(busy), .o_frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_data"},  out_data, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_eol"},   out_eol, 0);
    chk({tag, "_last"},  out_last, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_fd"},    frame_done, 0);
  endtask

  // rmode: 0 ready=1, 1 fixed pattern, 2 random. restart5: extra start in cycle 5. rst6: reset in cycle 6.
  task automatic run_frame(input int rmode, input bit restart5, input bit rst6);
    int c, n_acc, n_fd;
    bit stall, done, rdy;
    logic [SIZE-1:0] hold;
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    c = 0; n_acc = 0; n_fd = 0; stall = 0; done = 0; hold = '0;
    while (!done && c < 300) begin
      start = (c == 0) || (restart5 && c == 5);
      rst   = rst6 && (c == 6);
      if (rst6 && c == 7) begin
        chk_zero("midrst");
        done = 1;
      end else begin
        if (stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, hold);
        end
        chk("fd_and_valid", frame_done & out_valid, 0);
        if (raddr != 0) chk("raddr_ahead", raddr <= n_acc + 2, 1);
        if (rmode == 0 && !rst6) begin
          chk("t_valid", out_valid, (c >= 3 && c <= 10));
          chk("t_busy", busy, (c >= 1 && c <= 10));
          chk("t_fd", frame_done, (c == 11));
        end
        case (rmode)
          0:       rdy = 1;
          1:       rdy = pat[c % 6] != 0;
          default: rdy = $urandom_range(0, 1) != 0;
        endcase
        out_ready = rdy;
        if (out_valid && rdy) begin
          chk("word_cnt", n_acc < DEPTH, 1);
          chk("data", out_data, mem[n_acc % DEPTH]);
          chk("eol", out_eol, (n_acc % COLS) == COLS - 1);
          chk("last", out_last, (n_acc % DEPTH) == DEPTH - 1);
          n_acc++;
        end
        if (frame_done) begin
          n_fd++;
          done = 1;
        end
        stall = out_valid && !rdy;
        hold  = out_data;
      end
      tick();
      c++;
    end
    start = 0; rst = 0;
    if (!done) chk("timeout", 0, 1);
    if (!rst6) begin
      chk("n_words", n_acc, DEPTH);
      chk("n_fd", n_fd, 1);
      for (int i = 0; i < 4; i++) begin
        out_ready = $urandom_range(0, 1) != 0;
        chk("post_busy", busy, 0);
        chk("post_valid", out_valid, 0);
        chk("post_fd", frame_done, 0);
        tick();
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = SIZE'(8'hA0 + i);
    rst = 1; start = 0; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      start = $urandom_range(0, 1) != 0;
      out_ready = $urandom_range(0, 1) != 0;
      tick();
    end
    chk_zero("rst");
    rst = 0; start = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_raddr", raddr, 0);
      chk("idle_busy", busy, 0);
    end
`ifdef RAM_FRAME_READER_REPEAT_EN
    begin
      int c;
      for (c = 0; c < 45; c++) begin
        start = (c == 0);
        out_ready = 1;
        chk("rep_valid", out_valid, c >= 3);
        chk("rep_busy", busy, c >= 1);
        chk("rep_fd", frame_done, (c >= 11) && ((c - 11) % DEPTH == 0));
        if (c >= 3) begin
          chk("rep_data", out_data, mem[(c - 3) % DEPTH]);
          chk("rep_last", out_last, ((c - 3) % DEPTH) == DEPTH - 1);
          chk("rep_eol", out_eol, ((c - 3) % COLS) == COLS - 1);
        end
        tick();
      end
      rst = 1; start = 0;
      tick();
      rst = 0;
      chk_zero("rep_rst");
    end
`else
    run_frame(0, 0, 0);
    run_frame(1, 0, 0);
    run_frame(0, 1, 0);
    run_frame(0, 0, 1);
    run_frame(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = SIZE'($urandom);
      run_frame(2, 0, 0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
